// File: rtl/usb_dev_rw_responder.sv
// ============================================================================
// Module   : usb_dev_rw_responder
// Purpose  : Device-side responder for the host page read/write protocol.
//            An OUT to ADDR_ENDP latches a 16-bit page and starts a prefetch
//            of that page. An OUT to DATA_ENDP writes 64 bits to the page.
//            An IN to DATA_ENDP returns the prefetched 64 bits.
//            The block sits between the device protocol FSM and a
//            variable-latency 64-bit page memory.
// Config   : `define PAGE_CHECK_EN to reject address OUTs whose page number
//            is >= MEM_PAGES with a STALL. MEM_PAGES exists only in that build.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            i_rx_*             - decoded token from the protocol FSM
//            i_rx_abort         - protocol FSM dropped the current transaction
//            o_rsp_*/i_rsp_ready- handshake/data response to the protocol FSM
//            o_mem_*/i_mem_*    - page memory request/ack interface
//            o_page_valid       - address latched and transaction still open
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_dev_rw_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8
`ifdef PAGE_CHECK_EN
  , parameter int       MEM_PAGES = 4096
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_valid,
  input  logic        i_rx_in,
  input  logic [6:0]  i_rx_addr,
  input  logic [3:0]  i_rx_endp,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_abort,
  output logic        o_rsp_valid,
  output logic [1:0]  o_rsp_code,
  output logic [63:0] o_rsp_data,
  input  logic        i_rsp_ready,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_page_valid
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_MEM_WR   = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam logic [1:0] C_ACK   = 2'd0;
  localparam logic [1:0] C_NAK   = 2'd1;
  localparam logic [1:0] C_STALL = 2'd2;
  localparam logic [1:0] C_DATA  = 2'd3;

  state_t      r_state;
  state_t      r_ret;        // where RESP goes once the response is done
  logic [15:0] r_page;
  logic        r_page_valid;
  logic [63:0] r_rbuf;
  logic        r_rbuf_valid;
  logic [63:0] r_wdata;
  logic        r_rd_pend;    // read issued and not yet acknowledged
  logic        r_wabort;     // abort seen during MEM_WR: suppress its ACK
  logic [1:0]  r_rsp_code;
  logic [63:0] r_rsp_data;

  state_t      w_state_nxt;
  state_t      w_ret_nxt;
  state_t      w_exit_tgt;
  logic        w_hit;
  logic        w_page_ok;
  logic        w_mem_rd;
  logic        w_rd_done;
  logic        w_load_rsp;
  logic [1:0]  w_code_nxt;
  logic        w_load_data;
  logic        w_latch_page;
  logic        w_latch_wdata;
  logic        w_clr_valid;
  logic        w_wabort_nxt;

  assign w_hit = i_rx_valid && (i_rx_addr == DEV_ADDR);

`ifdef PAGE_CHECK_EN
  assign w_page_ok = ({16'd0, i_rx_data[15:0]} < MEM_PAGES);
`else
  assign w_page_ok = 1'b1;
`endif

  // A read that was already issued stays asserted while a NAK is being
  // returned, so the memory sees one continuous request until its ack.
  assign w_mem_rd  = (r_state == S_PREFETCH) || ((r_state == S_RESP) && r_rd_pend);
  assign w_rd_done = w_mem_rd && i_mem_ack;

  // Leaving RESP returns to PREFETCH only while the page still has to be
  // loaded; a read that completes during RESP makes that unnecessary.
  assign w_exit_tgt = ((r_ret == S_PREFETCH) && !w_rd_done) ? S_PREFETCH : S_IDLE;

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_load_rsp    = 1'b0;
    w_code_nxt    = C_ACK;
    w_load_data   = 1'b0;
    w_latch_page  = 1'b0;
    w_latch_wdata = 1'b0;
    w_clr_valid   = 1'b0;
    w_wabort_nxt  = r_wabort;

    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_load_rsp  = 1'b1;
          w_state_nxt = S_RESP;
          w_ret_nxt   = S_IDLE;
          w_code_nxt  = C_STALL;
          if (!i_rx_in && (i_rx_endp == ADDR_ENDP)) begin
            if (w_page_ok) begin
              w_latch_page = 1'b1;
              w_code_nxt   = C_ACK;
              w_ret_nxt    = S_PREFETCH;
            end
          end else if (!i_rx_in && (i_rx_endp == DATA_ENDP)) begin
            if (r_page_valid) begin
              w_load_rsp    = 1'b0;
              w_state_nxt   = S_MEM_WR;
              w_latch_wdata = 1'b1;
              w_wabort_nxt  = 1'b0;
            end
          end else if (i_rx_in && (i_rx_endp == DATA_ENDP)) begin
            if (r_rbuf_valid) begin
              w_code_nxt  = C_DATA;
              w_load_data = 1'b1;
            end else if (r_page_valid) begin
              // Page known but not loaded yet: ask the host to retry.
              w_code_nxt = C_NAK;
            end
          end
        end
      end

      S_PREFETCH: begin
        if (w_hit) begin
          w_load_rsp  = 1'b1;
          w_code_nxt  = C_NAK;
          w_state_nxt = S_RESP;
          w_ret_nxt   = w_rd_done ? S_IDLE : S_PREFETCH;
        end else if (w_rd_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_MEM_WR: begin
        if (i_rx_abort) begin
          w_wabort_nxt = 1'b1;
        end
        if (i_mem_ack) begin
          w_clr_valid = 1'b1;
          if (r_wabort || i_rx_abort) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load_rsp  = 1'b1;
            w_code_nxt  = C_ACK;
            w_state_nxt = S_RESP;
            w_ret_nxt   = S_IDLE;
          end
        end
      end

      S_RESP: begin
        if (w_rd_done) begin
          w_ret_nxt = S_IDLE;
        end
        // rsp_ready takes priority over a simultaneous abort.
        if (i_rsp_ready) begin
          w_state_nxt = w_exit_tgt;
          if (r_rsp_code == C_DATA) begin
            w_clr_valid = 1'b1;
          end
        end else if (i_rx_abort) begin
          w_state_nxt = w_exit_tgt;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ret        <= S_IDLE;
      r_page       <= 16'd0;
      r_page_valid <= 1'b0;
      r_rbuf       <= 64'd0;
      r_rbuf_valid <= 1'b0;
      r_wdata      <= 64'd0;
      r_rd_pend    <= 1'b0;
      r_wabort     <= 1'b0;
      r_rsp_code   <= C_ACK;
      r_rsp_data   <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ret    <= w_ret_nxt;
      r_wabort <= w_wabort_nxt;

      if (w_latch_page) begin
        r_page       <= i_rx_data[15:0];
        r_page_valid <= 1'b1;
        r_rbuf_valid <= 1'b0;
      end

      if (w_latch_wdata) begin
        r_wdata <= i_rx_data;
      end

      if (w_clr_valid) begin
        r_page_valid <= 1'b0;
        r_rbuf_valid <= 1'b0;
      end

      if (w_rd_done) begin
        r_rbuf       <= i_mem_rdata;
        r_rbuf_valid <= 1'b1;
        r_rd_pend    <= 1'b0;
      end else if (r_state == S_PREFETCH) begin
        r_rd_pend <= 1'b1;
      end

      if (w_load_rsp) begin
        r_rsp_code <= w_code_nxt;
        r_rsp_data <= w_load_data ? r_rbuf : 64'd0;
      end
    end
  end

  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_code   = o_rsp_valid ? r_rsp_code : 2'd0;
  assign o_rsp_data   = o_rsp_valid ? r_rsp_data : 64'd0;
  assign o_mem_rd     = w_mem_rd;
  assign o_mem_wr     = (r_state == S_MEM_WR);
  assign o_mem_addr   = (w_mem_rd || o_mem_wr) ? r_page : 16'd0;
  assign o_mem_wdata  = o_mem_wr ? r_wdata : 64'd0;
  assign o_page_valid = r_page_valid;

endmodule

`default_nettype wire

// File: tb/tb_usb_dev_rw_responder.sv
// ============================================================================
// Module   : tb_usb_dev_rw_responder
// Purpose  : Directed self-checking bench for usb_dev_rw_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_dev_rw_responder;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic        rx_in;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [63:0] rx_data;
  logic        rx_abort;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic [63:0] rsp_data;
  logic        rsp_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        page_valid;

  int n_checks = 0;
  int n_errors = 0;

  usb_dev_rw_responder dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_valid   (rx_valid),
    .i_rx_in      (rx_in),
    .i_rx_addr    (rx_addr),
    .i_rx_endp    (rx_endp),
    .i_rx_data    (rx_data),
    .i_rx_abort   (rx_abort),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_code   (rsp_code),
    .o_rsp_data   (rsp_data),
    .i_rsp_ready  (rsp_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ack    (mem_ack),
    .o_page_valid (page_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic in_, input logic [6:0] a, input logic [3:0] e,
                      input logic [63:0] d);
    rx_valid = 1'b1;
    rx_in    = in_;
    rx_addr  = a;
    rx_endp  = e;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_in    = 1'b0;
    rx_data  = 64'd0;
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!mem_rd && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, mem_rd}, 64'd1);
  endtask

  task automatic mem_done(input logic [63:0] d);
    mem_rdata = d;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
  endtask

  // Address OUT, ACK consumed, prefetch completed immediately with d.
  task automatic load_page(input logic [15:0] pg, input logic [63:0] d);
    send(1'b0, 7'd5, 4'd4, {48'd0, pg});
    chk("addr_ack_code", {62'd0, rsp_code}, 64'd0);
    consume();
    wait_rd("prefetch_rd");
    chk("prefetch_addr", {48'd0, mem_addr}, {48'd0, pg});
    mem_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_in = 1'b0; rx_addr = 7'd0; rx_endp = 4'd0;
    rx_data = 64'd0; rx_abort = 1'b0; rsp_ready = 1'b0; mem_rdata = 64'd0; mem_ack = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("reset_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("reset_page_valid", {63'd0, page_valid}, 64'd0);

    // STALL cases
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("in_after_reset_valid", {63'd0, rsp_valid}, 64'd1);
    chk("in_after_reset_stall", {62'd0, rsp_code}, 64'd2);
    consume();
    chk("stall_consumed", {63'd0, rsp_valid}, 64'd0);
    send(1'b0, 7'd5, 4'd3, 64'h55);
    chk("out_endp3_stall", {62'd0, rsp_code}, 64'd2);
    consume();
    send(1'b0, 7'd6, 4'd4, 64'h12);
    chk("wrong_addr_no_rsp", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("wrong_addr_no_rsp2", {63'd0, rsp_valid}, 64'd0);
    chk("wrong_addr_no_page", {63'd0, page_valid}, 64'd0);

    // Read
    send(1'b0, 7'd5, 4'd4, 64'h0012);
    chk("rd_addr_ack_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rd_addr_ack_code", {62'd0, rsp_code}, 64'd0);
    chk("rd_page_valid", {63'd0, page_valid}, 64'd1);
    consume();
    chk("rd_mem_rd", {63'd0, mem_rd}, 64'd1);
    chk("rd_mem_addr", {48'd0, mem_addr}, 64'h0012);
    tick(); tick();
    chk("rd_mem_rd_held", {63'd0, mem_rd}, 64'd1);
    mem_done(64'hDEADBEEF_CAFEF00D);
    chk("rd_mem_rd_drop", {63'd0, mem_rd}, 64'd0);
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("rd_data_code", {62'd0, rsp_code}, 64'd3);
    chk("rd_data_value", rsp_data, 64'hDEADBEEF_CAFEF00D);
    tick();
    chk("rd_data_stable", rsp_data, 64'hDEADBEEF_CAFEF00D);
    consume();
    chk("rd_page_valid_clr", {63'd0, page_valid}, 64'd0);

    // Abort during DATA response, then retry
    load_page(16'h0200, 64'hA5A5_0123_4567_5A5A);
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("ab_data_code", {62'd0, rsp_code}, 64'd3);
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    chk("ab_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    chk("ab_page_kept", {63'd0, page_valid}, 64'd1);
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("ab_retry_code", {62'd0, rsp_code}, 64'd3);
    chk("ab_retry_data", rsp_data, 64'hA5A5_0123_4567_5A5A);
    consume();

    // NAK while prefetch outstanding
    send(1'b0, 7'd5, 4'd4, 64'h0300);
    consume();
    chk("nak_mem_rd", {63'd0, mem_rd}, 64'd1);
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("nak_code", {62'd0, rsp_code}, 64'd1);
    chk("nak_rd_held", {63'd0, mem_rd}, 64'd1);
    consume();
    chk("nak_resume_rd", {63'd0, mem_rd}, 64'd1);
    chk("nak_resume_addr", {48'd0, mem_addr}, 64'h0300);
    for (int i = 0; i < 5; i++) tick();
    mem_done(64'h0BAD_F00D_1234_8765);
    send(1'b1, 7'd5, 4'd8, 64'd0);
    chk("nak_retry_code", {62'd0, rsp_code}, 64'd3);
    chk("nak_retry_data", rsp_data, 64'h0BAD_F00D_1234_8765);
    consume();

    // Write
    load_page(16'h0100, 64'h77);
    send(1'b0, 7'd5, 4'd8, 64'h1122334455667788);
    chk("wr_mem_wr", {63'd0, mem_wr}, 64'd1);
    chk("wr_mem_addr", {48'd0, mem_addr}, 64'h0100);
    chk("wr_mem_wdata", mem_wdata, 64'h1122334455667788);
    chk("wr_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
    tick(); tick();
    chk("wr_held", {63'd0, mem_wr}, 64'd1);
    mem_done(64'd0);
    chk("wr_ack_valid", {63'd0, rsp_valid}, 64'd1);
    chk("wr_ack_code", {62'd0, rsp_code}, 64'd0);
    chk("wr_mem_wr_drop", {63'd0, mem_wr}, 64'd0);
    chk("wr_page_valid_clr", {63'd0, page_valid}, 64'd0);
    consume();

    // Reset during MEM_WR
    load_page(16'h0042, 64'h1);
    send(1'b0, 7'd5, 4'd8, 64'hFFFF_0000_FFFF_0000);
    chk("rst_wr_active", {63'd0, mem_wr}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_page_valid", {63'd0, page_valid}, 64'd0);

`ifdef PAGE_CHECK_EN
    send(1'b0, 7'd5, 4'd4, 64'h1000);
    chk("pc_stall_code", {62'd0, rsp_code}, 64'd2);
    chk("pc_page_invalid", {63'd0, page_valid}, 64'd0);
    consume();
    tick();
    chk("pc_no_mem_rd", {63'd0, mem_rd}, 64'd0);
`else
    send(1'b0, 7'd5, 4'd4, 64'hFFFF);
    chk("top_page_ack", {62'd0, rsp_code}, 64'd0);
    consume();
    chk("top_page_rd_addr", {48'd0, mem_addr}, 64'hFFFF);
    mem_done(64'd9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
